// File: rtl/cic_pkg.sv
// Shared constants, types and ratio/shift helpers for the CIC decimator.
package cic_pkg;

    localparam int STAGES  = 3;
    localparam int IN_W    = 8;
    localparam int OUT_W   = 8;
    localparam int RATIO_W = 16;
    localparam int ACC_W   = IN_W + STAGES * RATIO_W;
    localparam int LOG_W   = $clog2(RATIO_W + 1);
    localparam int SHIFT_W = $clog2(STAGES * RATIO_W + 1);

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic [RATIO_W-1:0]      ratio_t;
    typedef logic [LOG_W-1:0]        log_t;
    typedef logic [SHIFT_W-1:0]      shift_t;

    // A ratio of 0 is treated as 1 so the counter compare never underflows.
    function automatic ratio_t ratio_eff(input ratio_t r);
        return (r == '0) ? ratio_t'(1) : r;
    endfunction

    // ceil(log2(r_eff)) via leading-one detect of r_eff-1; r_eff==1 gives 0.
    function automatic log_t clog2_runtime(input ratio_t r_eff);
        ratio_t m;
        log_t   msb;
        m   = r_eff - ratio_t'(1);
        msb = '0;
        for (int i = 0; i < RATIO_W; i++) begin
            if (m[i]) msb = log_t'(i + 1);
        end
        return msb;
    endfunction

    function automatic shift_t shift_for(input ratio_t r_eff);
        return shift_t'(STAGES * int'(clog2_runtime(r_eff)));
    endfunction

endpackage

// File: rtl/cic_shift_sat.sv
// Variable arithmetic right shift of the comb result with saturation to OUT_W.
// Optional round-half-up before the shift when CIC_ROUND_EN is defined.
module cic_shift_sat
    import cic_pkg::*;
(
    input  acc_t                    din,
    input  shift_t                  shift,
    output logic signed [OUT_W-1:0] dout
);

    localparam acc_t OUT_MAX = acc_t'((1 <<< (OUT_W - 1)) - 1);
    localparam acc_t OUT_MIN = acc_t'(-(1 <<< (OUT_W - 1)));

    acc_t biased;
    acc_t shifted;

    // NOTE: every variable gets a value before any branch so no latch is inferred.
    always_comb begin
        biased = din;
`ifdef CIC_ROUND_EN
        if (shift != '0) biased = din + (acc_t'(1) <<< (shift - shift_t'(1)));
`endif
        shifted = biased >>> shift;
        if (shifted > OUT_MAX)      dout = OUT_MAX[OUT_W-1:0];
        else if (shifted < OUT_MIN) dout = OUT_MIN[OUT_W-1:0];
        else                        dout = shifted[OUT_W-1:0];
    end

endmodule

// File: rtl/cic_decimator.sv
// Runtime-programmable N-stage CIC decimator (M=1) with power-of-two gain normalisation.
// Define CIC_ROUND_EN to round half-up instead of truncating in the output scaler.
module cic_decimator
    import cic_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RATIO_W-1:0]      decimation_ratio,
    input  logic signed [IN_W-1:0]  d_in,
    output logic signed [OUT_W-1:0] d_out,
    output logic                    d_clk
);

    ratio_t                  cnt;
    ratio_t                  ratio_q;
    ratio_t                  next_ratio;
    shift_t                  shift_q;
    logic                    armed;
    logic                    dec;
    acc_t                    comb_out;
    logic signed [OUT_W-1:0] scaled;

    assign next_ratio = ratio_eff(decimation_ratio);
    assign dec        = armed && (cnt == ratio_q - ratio_t'(1));

    // Integrators run every cycle and wrap modulo 2^ACC_W by design.
    for (genvar k = 0; k < STAGES; k++) begin : g_integ
        acc_t acc;
        acc_t addend;
        if (k == 0) begin : g_first
            assign addend = acc_t'(d_in);
        end else begin : g_chain
            assign addend = g_integ[k-1].acc;
        end
        always_ff @(posedge clk) begin
            if (!rst) acc <= '0;
            else      acc <= acc + addend;
        end
    end

    // Comb differences are combinational; only the delays are clocked, on decimation cycles.
    for (genvar k = 0; k < STAGES; k++) begin : g_comb
        acc_t c_in;
        acc_t c_out;
        acc_t dly;
        if (k == 0) begin : g_first
            assign c_in = g_integ[STAGES-1].acc;
        end else begin : g_chain
            assign c_in = g_comb[k-1].c_out;
        end
        assign c_out = c_in - dly;
        always_ff @(posedge clk) begin
            if (!rst)     dly <= '0;
            else if (dec) dly <= c_in;
        end
    end

    assign comb_out = g_comb[STAGES-1].c_out;

    cic_shift_sat u_shift_sat (
        .din   (comb_out),
        .shift (shift_q),
        .dout  (scaled)
    );

    // The first edge out of reset latches the ratio, so frame 0 is a full R_eff cycles long.
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            ratio_q <= ratio_t'(1);
            shift_q <= '0;
            armed   <= 1'b0;
            d_out   <= '0;
            d_clk   <= 1'b0;
        end else begin
            d_clk <= dec;
            if (dec) d_out <= scaled;
            if (!armed || dec) begin
                armed   <= 1'b1;
                cnt     <= '0;
                ratio_q <= next_ratio;
                shift_q <= shift_for(next_ratio);
            end else begin
                cnt <= cnt + ratio_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: behavioural model compared every cycle,
// plus hand-computed settled outputs, strobe timing and latency checks.
module tb_cic_decimator;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       decimation_ratio;
    logic signed [7:0] d_in;
    logic signed [7:0] d_out;
    logic              d_clk;

    int checks = 0;
    int errors = 0;

    cic_decimator dut (
        .clk              (clk),
        .rst              (rst),
        .decimation_ratio (decimation_ratio),
        .d_in             (d_in),
        .d_out            (d_out),
        .d_clk            (d_clk)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] actual,
                         input logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint wrap56(input longint v);
        return (v <<< 8) >>> 8;
    endfunction

    function automatic int ceil_log2(input int r);
        int s = 0;
        while ((longint'(1) << s) < longint'(r)) s++;
        return s;
    endfunction

    function automatic longint scale(input longint c, input int s);
        longint v = c;
`ifdef CIC_ROUND_EN
        if (s > 0) v = c + (longint'(1) << (s - 1));
`endif
        v = v >>> s;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    longint m_i1, m_i2, m_i3;
    longint m_x0, m_x1, m_x2, m_x3;   // last four decimated integrator samples
    int     m_pos, m_len, m_s;
    bit     m_armed, m_dec, live = 1'b0;
    longint exp_out;
    bit     exp_clk;

    // Output is the third difference of the decimated integrator sequence, scaled by 2^-S.
    always @(posedge clk) begin
        live = 1'b1;
        if (!rst) begin
            m_i1 = 0; m_i2 = 0; m_i3 = 0;
            m_x0 = 0; m_x1 = 0; m_x2 = 0; m_x3 = 0;
            m_pos = 0; m_len = 1; m_s = 0; m_armed = 1'b0;
            exp_out = 0; exp_clk = 1'b0;
        end else begin
            m_dec = m_armed && (m_pos == m_len - 1);
            if (m_dec) begin
                m_x3 = m_x2; m_x2 = m_x1; m_x1 = m_x0; m_x0 = m_i3;
                exp_out = scale(wrap56(m_x0 - 3 * m_x1 + 3 * m_x2 - m_x3), m_s);
            end
            exp_clk = m_dec;
            m_i3 = wrap56(m_i3 + m_i2);
            m_i2 = wrap56(m_i2 + m_i1);
            m_i1 = wrap56(m_i1 + longint'(d_in));
            if (!m_armed || m_dec) begin
                m_armed = 1'b1;
                m_pos   = 0;
                m_len   = (decimation_ratio == 0) ? 1 : int'(decimation_ratio);
                m_s     = 3 * ceil_log2(m_len);
            end else begin
                m_pos++;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("model_d_clk", d_clk, exp_clk);
            check("model_d_out", d_out, exp_out);
        end
    end

    // ---------------- stimulus ----------------
    // Returns one negedge after the release edge, so a strobe after R_eff cycles reads R_eff.
    task automatic reset_run(input int ratio, input int din);
        rst = 1'b0;
        decimation_ratio = 16'(ratio);
        d_in = 8'(din);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_strobe(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (d_clk !== 1'b1 && cycles < budget);
        if (d_clk !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout: d_clk=%b after %0d cycles, required high", d_clk, cycles);
        end
    endtask

    initial begin
        int n;
        rst = 1'b0;
        decimation_ratio = 16'd16;
        d_in = 8'sd0;

        // Reset with random input: outputs must stay zero.
        repeat (10) begin
            d_in = 8'($urandom);
            @(negedge clk);
            check("reset_d_out", d_out, 0);
            check("reset_d_clk", d_clk, 0);
        end

        // R=16, DC 64: first strobe after 16 cycles, period 16, settled output 64.
        d_in = 8'sd64;
        rst = 1'b1;
        @(negedge clk);
        wait_strobe(40, n);
        check("first_strobe_delay", n, 16);
        wait_strobe(40, n);
        check("strobe_period_16", n, 16);
        repeat (2) wait_strobe(40, n);
        check("dc_r16_pos64", d_out, 64);

        reset_run(16, -128);
        repeat (4) wait_strobe(40, n);
        check("dc_r16_neg128", d_out, -128);

        // R=1000, S=30: gain 1e9/2^30 = 0.9313.
        reset_run(1000, 100);
        repeat (4) wait_strobe(1100, n);
        check("dc_r1000_pos100", d_out, 93);
        reset_run(1000, -100);
        repeat (4) wait_strobe(1100, n);
`ifdef CIC_ROUND_EN
        check("dc_r1000_neg100", d_out, -93);
`else
        check("dc_r1000_neg100", d_out, -94);
`endif

        // R=12500, S=42: gain 0.4441.
        reset_run(12500, 100);
        repeat (4) wait_strobe(13000, n);
        check("dc_r12500_pos100", d_out, 44);

        // Square wave +-100, period 128 cycles at R=16; model covers every cycle.
        reset_run(16, 100);
        for (int c = 0; c < 1024; c++) begin
            d_in = (((c / 64) % 2) == 0) ? 8'sd100 : -8'sd100;
            @(negedge clk);
        end

        // Ratio change 16 -> 8 at counter 5: current frame still ends at 16.
        reset_run(16, 64);
        repeat (4) wait_strobe(40, n);
        check("pre_change_dc", d_out, 64);
        repeat (5) @(negedge clk);
        decimation_ratio = 16'd8;
        wait_strobe(40, n);
        check("frame_after_change", n, 11);
        wait_strobe(40, n);
        check("strobe_period_8", n, 8);
        repeat (6) wait_strobe(40, n);
        check("dc_r8_pos64", d_out, 64);

        // R=0 acts as R=1: strobe every cycle, identity with 4-cycle latency.
        reset_run(0, 37);
        wait_strobe(4, n);
        check("r0_first_strobe", n, 1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("r0_strobe_held", d_clk, 1);
        end
        check("r0_dc", d_out, 37);
        d_in = -8'sd5;
        repeat (3) @(negedge clk);
        check("r0_latency_before", d_out, 37);
        @(negedge clk);
        check("r0_latency_after", d_out, -5);

        reset_run(1, -20);
        wait_strobe(4, n);
        check("r1_first_strobe", n, 1);
        repeat (10) @(negedge clk);
        check("r1_strobe_held", d_clk, 1);
        check("r1_dc", d_out, -20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
